matrix_store_writer: RTL and testbench

Write-side owner of the matrix store. Accepts a matrix (dimensions plus a row-major element stream), allocates one of `NUM_SLOTS` slots, writes the elements, and publishes the per-slot metadata vectors read by the operand selector. It also serves element reads to the compute engine and handles slot deletion.

---
 rtl/matrix_store_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_matrix_store_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store_writer.sv
// matrix_store_writer: write-side owner of the matrix store.
// Allocates a slot, receives a row-major element stream, publishes
// per-slot metadata and serves registered element reads.
// Optional feature macro: MATRIX_STORE_OVERWRITE_EN (victim overwrite
// when every slot is valid; otherwise a full store is rejected).
module matrix_store_writer #(
    parameter int NUM_SLOTS = 10,
    parameter int DATA_W    = 8,
    parameter int MAX_DIM   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_start,
    input  logic [2:0]             wr_m,
    input  logic [2:0]             wr_n,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   wr_data_valid,
    output logic                   wr_ready,
    input  logic                   wr_abort,
    output logic                   wr_done,
    output logic [3:0]             wr_id,
    output logic                   wr_error,
    input  logic                   del_req,
    input  logic [3:0]             del_id,
    input  logic [3:0]             rd_slot,
    input  logic [4:0]             rd_idx,
    output logic [DATA_W-1:0]      rd_data,
    output logic [3*NUM_SLOTS-1:0] meta_m_flat,
    output logic [3*NUM_SLOTS-1:0] meta_n_flat,
    output logic [NUM_SLOTS-1:0]   meta_valid_flat,
    output logic [3:0]             slot_count
);
    localparam int CELLS  = MAX_DIM * MAX_DIM;
    localparam int DEPTH  = NUM_SLOTS * CELLS;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ALLOC, RECV, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             m_q, m_d, n_q, n_d;
    logic [3:0]             slot_q, slot_d;
    logic [4:0]             idx_q, idx_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   wr_done_q, wr_done_d;
    logic                   wr_error_q, wr_error_d;
    logic [3:0]             wr_id_q, wr_id_d;
    logic [NUM_SLOTS-1:0]   valid_q, valid_d;
    logic [3*NUM_SLOTS-1:0] meta_m_q, meta_m_d, meta_n_q, meta_n_d;
    logic [3:0]             slot_count_q, slot_count_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
`ifdef MATRIX_STORE_OVERWRITE_EN
    logic [3:0]             vic_ptr_q, vic_ptr_d;
`endif

    logic [DATA_W-1:0]      mem [DEPTH];
    logic                   mem_we;
    logic [ADDR_W-1:0]      wr_addr, rd_addr;
    logic                   rd_in_range;
    logic [5:0]             elem_total;
    logic                   last_elem;
    logic                   free_found;
    logic [3:0]             free_slot;

    // Lowest-index slot whose valid bit is clear
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_slot  = 4'(i);
            end
        end
    end

    // Element addresses and end-of-matrix detection
    always_comb begin
        wr_addr     = ADDR_W'(slot_q) * ADDR_W'(CELLS) + ADDR_W'(idx_q);
        rd_addr     = ADDR_W'(rd_slot) * ADDR_W'(CELLS) + ADDR_W'(rd_idx);
        rd_in_range = (int'(rd_slot) < NUM_SLOTS) && (int'(rd_idx) < CELLS);
        elem_total  = 6'(m_q) * 6'(n_q);
        last_elem   = ({1'b0, idx_q} == (elem_total - 6'd1));
    end

    // Next-state, metadata, handshake outputs and read data
    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        n_d          = n_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        wr_done_d    = 1'b0;
        wr_error_d   = 1'b0;
        wr_id_d      = wr_id_q;
        valid_d      = valid_q;
        meta_m_d     = meta_m_q;
        meta_n_d     = meta_n_q;
        mem_we       = 1'b0;
`ifdef MATRIX_STORE_OVERWRITE_EN
        vic_ptr_d    = vic_ptr_q;
`endif
        rd_data_d    = rd_in_range ? mem[rd_addr] : '0;
        slot_count_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_count_d = slot_count_d + 4'(valid_q[i]);
        end

        case (state_q)
            IDLE: begin
                if (del_req && (int'(del_id) < NUM_SLOTS)) begin
                    valid_d[del_id] = 1'b0;
                end
                if (wr_start) begin
                    if (wr_m == 3'd0 || wr_n == 3'd0 ||
                        int'(wr_m) > MAX_DIM || int'(wr_n) > MAX_DIM) begin
                        wr_error_d = 1'b1;
                    end else begin
                        m_d     = wr_m;
                        n_d     = wr_n;
                        state_d = ALLOC;
                    end
                end
            end
            ALLOC: begin
                if (free_found) begin
                    slot_d             = free_slot;
                    valid_d[free_slot] = 1'b0;
                    idx_d              = '0;
                    state_d            = RECV;
                end else begin
`ifdef MATRIX_STORE_OVERWRITE_EN
                    slot_d             = vic_ptr_q;
                    valid_d[vic_ptr_q] = 1'b0;
                    vic_ptr_d          = (int'(vic_ptr_q) == NUM_SLOTS - 1) ? 4'd0 : vic_ptr_q + 4'd1;
                    idx_d              = '0;
                    state_d            = RECV;
`else
                    wr_error_d         = 1'b1;
                    state_d            = IDLE;
`endif
                end
            end
            RECV: begin
                if (wr_abort) begin
                    wr_error_d = 1'b1;
                    state_d    = IDLE;
                end else if (wr_data_valid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 5'd1;
                    if (last_elem) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                meta_m_d[int'(slot_q)*3 +: 3] = m_q;
                meta_n_d[int'(slot_q)*3 +: 3] = n_q;
                valid_d[slot_q]               = 1'b1;
                wr_id_d                       = slot_q;
                wr_done_d                     = 1'b1;
                state_d                       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ready_d = (state_d == RECV);
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            m_q          <= '0;
            n_q          <= '0;
            slot_q       <= '0;
            idx_q        <= '0;
            wr_ready_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_error_q   <= 1'b0;
            wr_id_q      <= '0;
            valid_q      <= '0;
            meta_m_q     <= '0;
            meta_n_q     <= '0;
            slot_count_q <= '0;
            rd_data_q    <= '0;
`ifdef MATRIX_STORE_OVERWRITE_EN
            vic_ptr_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            n_q          <= n_d;
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            wr_ready_q   <= wr_ready_d;
            wr_done_q    <= wr_done_d;
            wr_error_q   <= wr_error_d;
            wr_id_q      <= wr_id_d;
            valid_q      <= valid_d;
            meta_m_q     <= meta_m_d;
            meta_n_q     <= meta_n_d;
            slot_count_q <= slot_count_d;
            rd_data_q    <= rd_data_d;
`ifdef MATRIX_STORE_OVERWRITE_EN
            vic_ptr_q    <= vic_ptr_d;
`endif
        end
    end

    // Element memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign wr_ready        = wr_ready_q;
    assign wr_done         = wr_done_q;
    assign wr_error        = wr_error_q;
    assign wr_id           = wr_id_q;
    assign rd_data         = rd_data_q;
    assign meta_m_flat     = meta_m_q;
    assign meta_n_flat     = meta_n_q;
    assign meta_valid_flat = valid_q;
    assign slot_count      = slot_count_q;
endmodule

// File: tb/tb_matrix_store_writer.sv
// tb_matrix_store_writer: directed self-checking bench for matrix_store_writer.
// Expectations follow MATRIX_STORE_OVERWRITE_EN when it is defined.
module tb_matrix_store_writer;
    logic        clk;
    logic        rst_n;
    logic        wr_start;
    logic [2:0]  wr_m;
    logic [2:0]  wr_n;
    logic [7:0]  wr_data;
    logic        wr_data_valid;
    logic        wr_ready;
    logic        wr_abort;
    logic        wr_done;
    logic [3:0]  wr_id;
    logic        wr_error;
    logic        del_req;
    logic [3:0]  del_id;
    logic [3:0]  rd_slot;
    logic [4:0]  rd_idx;
    logic [7:0]  rd_data;
    logic [29:0] meta_m_flat;
    logic [29:0] meta_n_flat;
    logic [9:0]  meta_valid_flat;
    logic [3:0]  slot_count;

    int total = 0;
    int bad   = 0;

    matrix_store_writer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_start(wr_start), .wr_m(wr_m), .wr_n(wr_n),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_ready(wr_ready),
        .wr_abort(wr_abort), .wr_done(wr_done), .wr_id(wr_id), .wr_error(wr_error),
        .del_req(del_req), .del_id(del_id),
        .rd_slot(rd_slot), .rd_idx(rd_idx), .rd_data(rd_data),
        .meta_m_flat(meta_m_flat), .meta_n_flat(meta_n_flat),
        .meta_valid_flat(meta_valid_flat), .slot_count(slot_count)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic deleteSlot(input logic [3:0] id);
        del_req = 1'b1;
        del_id  = id;
        step();
        del_req = 1'b0;
        del_id  = '0;
    endtask

    task automatic readElem(input logic [3:0] slot, input logic [4:0] idx);
        rd_slot = slot;
        rd_idx  = idx;
        step();
    endtask

    // Run one store: elements base, base+1, ...; abortAfter>=0 aborts after that many
    // elements; delDuring>=0 raises a delete request while elements stream
    task automatic applyStimulus(input logic [2:0] m, input logic [2:0] n, input logic [7:0] base,
                                 input int abortAfter, input int delDuring,
                                 output int doneCycle, output int errSeen,
                                 output int readySeen, output logic [3:0] idOut);
        int cyc;
        int k;
        bit fin;
        doneCycle = -1;
        errSeen   = 0;
        readySeen = 0;
        idOut     = '0;
        k         = 0;
        fin       = 1'b0;
        wr_m      = m;
        wr_n      = n;
        wr_start  = 1'b1;
        step();
        wr_start  = 1'b0;
        cyc       = 1;
        while (cyc < 200 && !fin) begin
            wr_data_valid = 1'b0;
            wr_abort      = 1'b0;
            del_req       = 1'b0;
            if (wr_done) begin
                doneCycle = cyc;
                idOut     = wr_id;
                fin       = 1'b1;
            end else if (wr_error) begin
                errSeen = 1;
                fin     = 1'b1;
            end else begin
                if (wr_ready) begin
                    readySeen = 1;
                    if (delDuring >= 0) begin
                        del_req = 1'b1;
                        del_id  = 4'(delDuring);
                    end
                    if (abortAfter >= 0 && k == abortAfter) begin
                        wr_abort = 1'b1;
                    end else begin
                        wr_data_valid = 1'b1;
                        wr_data       = base + 8'(k);
                        k++;
                    end
                end
                step();
                cyc++;
            end
        end
        wr_data_valid = 1'b0;
        wr_abort      = 1'b0;
        del_req       = 1'b0;
        if (!fin) begin
            checkOutput("store_timeout", 32'(cyc), 32'd0);
        end
    endtask

    int         dc;
    int         es;
    int         rs;
    logic [3:0] id;
    logic [29:0] snapM;
    logic [29:0] snapN;
    logic [9:0]  snapV;

    initial begin
        rst_n = 1'b0; wr_start = 1'b0; wr_m = '0; wr_n = '0; wr_data = '0;
        wr_data_valid = 1'b0; wr_abort = 1'b0; del_req = 1'b0; del_id = '0;
        rd_slot = '0; rd_idx = '0;
        doReset();

        // Reset state
        checkOutput("rst_ready", 32'(wr_ready), 32'd0);
        checkOutput("rst_done", 32'(wr_done), 32'd0);
        checkOutput("rst_error", 32'(wr_error), 32'd0);
        checkOutput("rst_id", 32'(wr_id), 32'd0);
        checkOutput("rst_rdata", 32'(rd_data), 32'd0);
        checkOutput("rst_count", 32'(slot_count), 32'd0);
        checkOutput("rst_valid", 32'(meta_valid_flat), 32'd0);
        checkOutput("rst_meta_m", 32'(meta_m_flat), 32'd0);
        checkOutput("rst_meta_n", 32'(meta_n_flat), 32'd0);

        // Basic 2x3 store, elements 1..6
        applyStimulus(3'd2, 3'd3, 8'd1, -1, -1, dc, es, rs, id);
        checkOutput("s23_cycle", 32'(dc), 32'd9);
        checkOutput("s23_id", 32'(id), 32'd0);
        checkOutput("s23_valid", 32'(meta_valid_flat), 32'h001);
        checkOutput("s23_m0", 32'(meta_m_flat[2:0]), 32'd2);
        checkOutput("s23_n0", 32'(meta_n_flat[2:0]), 32'd3);
        readElem(4'd0, 5'd5);
        checkOutput("s23_done_pulse", 32'(wr_done), 32'd0);
        checkOutput("s23_rd5", 32'(rd_data), 32'd6);
        checkOutput("s23_count", 32'(slot_count), 32'd1);
        readElem(4'd0, 5'd0);
        checkOutput("s23_rd0", 32'(rd_data), 32'd1);
        readElem(4'd12, 5'd0);
        checkOutput("rd_bad_slot", 32'(rd_data), 32'd0);
        readElem(4'd0, 5'd25);
        checkOutput("rd_bad_idx", 32'(rd_data), 32'd0);

        // Illegal dimensions
        snapM = meta_m_flat; snapN = meta_n_flat; snapV = meta_valid_flat;
        applyStimulus(3'd6, 3'd2, 8'd0, -1, -1, dc, es, rs, id);
        checkOutput("dim6_err", 32'(es), 32'd1);
        checkOutput("dim6_ready", 32'(rs), 32'd0);
        step();
        checkOutput("dim6_pulse", 32'(wr_error), 32'd0);
        applyStimulus(3'd2, 3'd0, 8'd0, -1, -1, dc, es, rs, id);
        checkOutput("dim0_err", 32'(es), 32'd1);
        checkOutput("dim0_ready", 32'(rs), 32'd0);
        step();
        checkOutput("dim0_pulse", 32'(wr_error), 32'd0);
        checkOutput("dim_meta_m", 32'(meta_m_flat), 32'(snapM));
        checkOutput("dim_meta_n", 32'(meta_n_flat), 32'(snapN));
        checkOutput("dim_valid", 32'(meta_valid_flat), 32'(snapV));

        // Abort a 3x3 store after 4 elements; memory keeps slot 0 data from above
        doReset();
        applyStimulus(3'd3, 3'd3, 8'h10, 4, -1, dc, es, rs, id);
        checkOutput("abort_err", 32'(es), 32'd1);
        checkOutput("abort_valid", 32'(meta_valid_flat), 32'd0);
        readElem(4'd0, 5'd3);
        checkOutput("abort_rd3", 32'(rd_data), 32'h13);
        readElem(4'd0, 5'd4);
        checkOutput("abort_rd4_unwritten", 32'(rd_data), 32'd5);
        applyStimulus(3'd1, 3'd1, 8'h55, -1, -1, dc, es, rs, id);
        checkOutput("after_abort_id", 32'(id), 32'd0);
        checkOutput("after_abort_cycle", 32'(dc), 32'd4);
        readElem(4'd0, 5'd0);
        checkOutput("after_abort_rd", 32'(rd_data), 32'h55);

        // Fill slots 1..9
        for (int s = 1; s < 10; s++) begin
            applyStimulus(3'd1, 3'd1, 8'(s), -1, -1, dc, es, rs, id);
            checkOutput("fill_id", 32'(id), 32'(s));
        end
        checkOutput("fill_valid", 32'(meta_valid_flat), 32'h3FF);
        step();
        checkOutput("fill_count", 32'(slot_count), 32'd10);
        deleteSlot(4'd4);
        checkOutput("del4_valid", 32'(meta_valid_flat), 32'h3EF);
        step();
        checkOutput("del4_count", 32'(slot_count), 32'd9);
        applyStimulus(3'd1, 3'd1, 8'hA4, -1, -1, dc, es, rs, id);
        checkOutput("refill_id", 32'(id), 32'd4);
        step();
        checkOutput("refill_count", 32'(slot_count), 32'd10);

        // All slots full, two more 1x1 stores
        snapM = meta_m_flat; snapN = meta_n_flat; snapV = meta_valid_flat;
        applyStimulus(3'd1, 3'd1, 8'hC0, -1, -1, dc, es, rs, id);
`ifdef MATRIX_STORE_OVERWRITE_EN
        checkOutput("full1_id", 32'(id), 32'd0);
        checkOutput("full1_err", 32'(es), 32'd0);
`else
        checkOutput("full1_err", 32'(es), 32'd1);
        checkOutput("full1_ready", 32'(rs), 32'd0);
`endif
        applyStimulus(3'd1, 3'd1, 8'hC1, -1, -1, dc, es, rs, id);
`ifdef MATRIX_STORE_OVERWRITE_EN
        checkOutput("full2_id", 32'(id), 32'd1);
        checkOutput("full2_err", 32'(es), 32'd0);
`else
        checkOutput("full2_err", 32'(es), 32'd1);
        checkOutput("full2_ready", 32'(rs), 32'd0);
`endif
        checkOutput("full_meta_m", 32'(meta_m_flat), 32'(snapM));
        checkOutput("full_meta_n", 32'(meta_n_flat), 32'(snapN));
        checkOutput("full_valid", 32'(meta_valid_flat), 32'(snapV));

        // Ignored deletes: out-of-range id, and a request while receiving
        deleteSlot(4'd12);
        checkOutput("del12_valid", 32'(meta_valid_flat), 32'h3FF);
        deleteSlot(4'd7);
        checkOutput("del7_valid", 32'(meta_valid_flat), 32'h37F);
        applyStimulus(3'd2, 3'd2, 8'h70, -1, 2, dc, es, rs, id);
        checkOutput("recvdel_id", 32'(id), 32'd7);
        checkOutput("recvdel_cycle", 32'(dc), 32'd7);
        checkOutput("recvdel_valid", 32'(meta_valid_flat), 32'h3FF);
        checkOutput("recvdel_m7", 32'(meta_m_flat[23:21]), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
